neopixel_driver: RTL

NEOPIXEL_DRIVER -- requirements
Module: neopixel_driver

---
 rtl/neopixel_pkg.sv | 19 +
 rtl/neopixel_bit_timer.sv | 37 +++
 rtl/neopixel_driver.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/neopixel_pkg.sv
// Shared constants and state encoding for the WS2812 (NeoPixel) frame driver.
package neopixel_pkg;

  localparam int T0H_DEF     = 20;
  localparam int T1H_DEF     = 40;
  localparam int T_BIT_DEF   = 62;
  localparam int T_LATCH_DEF = 3000;
  localparam int PIXEL_W     = 24;
  localparam int WORD_W      = 32;
  localparam int ADDR_W      = 9;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    LATCH
  } state_t;

endpackage

// File: rtl/neopixel_bit_timer.sv
// Per-bit cycle counter: reports whether the current cycle is in the high phase
// of the bit being sent and strobes on the last cycle of each bit period.
module neopixel_bit_timer
  import neopixel_pkg::*;
#(
  parameter int T0H   = T0H_DEF,
  parameter int T1H   = T1H_DEF,
  parameter int T_BIT = T_BIT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic bit_val,
  output logic high_phase,
  output logic bit_end
);

  localparam int CW = $clog2(T_BIT);
  localparam logic [CW-1:0] LAST = CW'(T_BIT - 1);
  localparam logic [CW-1:0] HI0  = CW'(T0H);
  localparam logic [CW-1:0] HI1  = CW'(T1H);

  logic [CW-1:0] cnt;

  // Counter sits at zero whenever the timer is not running, so a bit always starts at cycle 0.
  always_ff @(posedge clock) begin
    if (reset || !run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_end    = run && (cnt == LAST);
  assign high_phase = run && (cnt < (bit_val ? HI1 : HI0));

endmodule

// File: rtl/neopixel_driver.sv
// WS2812 frame driver: reads NUM_LEDS GRB words from a registered pixel RAM and
// serialises them MSB first, followed by a low latch period and a done pulse.
module neopixel_driver
  import neopixel_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int T0H      = T0H_DEF,
  parameter int T1H      = T1H_DEF,
  parameter int T_BIT    = T_BIT_DEF,
  parameter int T_LATCH  = T_LATCH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [WORD_W-1:0] q,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  localparam int PIX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int BIT_W = $clog2(PIXEL_W);
  localparam int LAT_W = $clog2(T_LATCH + 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_LEDS - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PIXEL_W - 1);
  localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(T_LATCH);

  state_t state, state_next;

  logic [PIXEL_W-1:0] shift_reg;
  logic [PIXEL_W-1:0] shadow;
  logic [BIT_W-1:0]   bit_idx;
  logic [PIX_W-1:0]   pix_idx;
  logic [LAT_W-1:0]   lat_cnt;
  logic [1:0]         fetch_wait;
  logic               high_phase;
  logic               bit_end;
  logic               last_bit;
  logic               unused_upper;

  assign unused_upper = ^q[WORD_W-1:PIXEL_W];
  assign last_bit     = (bit_idx == LAST_BIT) && (pix_idx == LAST_PIX);

  neopixel_bit_timer #(
    .T0H  (T0H),
    .T1H  (T1H),
    .T_BIT(T_BIT)
  ) u_bit_timer (
    .clock     (clock),
    .reset     (reset),
    .run       (state == SEND),
    .bit_val   (shift_reg[PIXEL_W-1]),
    .high_phase(high_phase),
    .bit_end   (bit_end)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A start arriving in the done cycle is refused so each frame yields exactly one done.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !done) state_next = FETCH;
      FETCH:   if (fetch_wait == 2'd1) state_next = SEND;
      SEND:    if (bit_end && last_bit) state_next = LATCH;
      LATCH:   if (lat_cnt == LAT_END) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // fetch_wait counts the RAM's two-register read latency; the word is taken when it reaches 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdaddress  <= '0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      shift_reg  <= '0;
      shadow     <= '0;
      bit_idx    <= '0;
      pix_idx    <= '0;
      lat_cnt    <= '0;
      fetch_wait <= '0;
    end else begin
      done    <= (state == LATCH) && (state_next == IDLE);
      dout    <= high_phase;
      lat_cnt <= (state == LATCH && state_next == LATCH) ? lat_cnt + LAT_W'(1) : '0;
      if (fetch_wait != 2'd0) fetch_wait <= fetch_wait - 2'd1;

      case (state)
        IDLE: begin
          if (state_next == FETCH) begin
            rdaddress  <= '0;
            busy       <= 1'b1;
            fetch_wait <= 2'd3;
            pix_idx    <= '0;
            bit_idx    <= '0;
          end
        end
        FETCH: begin
          if (fetch_wait == 2'd1) begin
            shift_reg <= q[PIXEL_W-1:0];
            if (NUM_LEDS > 1) begin
              rdaddress  <= ADDR_W'(1);
              fetch_wait <= 2'd3;
            end
          end
        end
        SEND: begin
          if (fetch_wait == 2'd1) shadow <= q[PIXEL_W-1:0];
          if (bit_end) begin
            if (bit_idx == LAST_BIT) begin
              bit_idx <= '0;
              if (pix_idx != LAST_PIX) begin
                pix_idx   <= pix_idx + PIX_W'(1);
                shift_reg <= shadow;
                // Prefetch the word after the one just loaded, unless that would run past the frame.
                if ((pix_idx + PIX_W'(1)) < LAST_PIX) begin
                  rdaddress  <= ADDR_W'(pix_idx) + ADDR_W'(2);
                  fetch_wait <= 2'd3;
                end
              end
            end else begin
              bit_idx   <= bit_idx + BIT_W'(1);
              shift_reg <= {shift_reg[PIXEL_W-2:0], 1'b0};
            end
          end
        end
        LATCH: begin
          if (state_next == IDLE) busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
